// File: rtl/menu_button_pixel_gen.sv
// Menu button pixel generator: per-button hover/press/flash FSMs, click pulses and RGB444 colouring.
// Optional keyboard navigation (focus, key_next, key_select) is enabled by MENU_BTN_KEYNAV_EN.
module menu_button_pixel_gen #(
   parameter int          NUM_BTN      = 4,
   parameter int          IDX_W        = 3,
   parameter int          FLASH_FRAMES = 8,
   parameter logic [11:0] C_WHITE      = 12'hFFF,
   parameter logic [11:0] C_BLACK      = 12'h000,
   parameter logic [11:0] C_TOUCH      = 12'h32E,
   parameter logic [11:0] C_CLICK      = 12'hDD2,
   parameter logic [11:0] C_LOCK       = 12'h1E1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               pixel_valid,
   input  logic [IDX_W-1:0]   mem_idx,
   input  logic [NUM_BTN-1:0] mouse_hover,
   input  logic               mouse_left,
   input  logic [NUM_BTN-1:0] btn_lock,
`ifdef MENU_BTN_KEYNAV_EN
   input  logic               key_next,
   input  logic               key_select,
`endif
   output logic [11:0]        pixel_out,
   output logic               pixel_out_valid,
   output logic [NUM_BTN-1:0] btn_click
);

   localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOVER = 2'd1,
      S_PRESS = 2'd2,
      S_FLASH = 2'd3
   } state_t;

   state_t             state_q [NUM_BTN];
   state_t             state_d [NUM_BTN];
   logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
   logic [11:0]        btn_col [NUM_BTN];
   logic [NUM_BTN-1:0] btn_click_d;
   logic [NUM_BTN-1:0] raw_hov;
   logic [NUM_BTN-1:0] hov;
   logic               found;
   logic               left_q;
   logic               left_d;
   logic               left_rise;
   logic               left_fall;
   logic [11:0]        pixel_out_d;
   logic               pixel_out_valid_d;

`ifdef MENU_BTN_KEYNAV_EN
   localparam int FOCUS_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
   logic [FOCUS_W-1:0] focus_q;
   logic [FOCUS_W-1:0] focus_d;

   always_comb begin
      focus_d = focus_q;
      if (key_next) begin
         if (focus_q == FOCUS_W'(NUM_BTN - 1)) begin
            focus_d = '0;
         end else begin
            focus_d = focus_q + FOCUS_W'(1);
         end
      end else begin
         focus_d = focus_q;
      end
   end
`endif

   // Hover arbitration: only the lowest-numbered hovered button counts
   always_comb begin
      raw_hov = mouse_hover;
`ifdef MENU_BTN_KEYNAV_EN
      if (mouse_hover == '0) begin
         raw_hov = NUM_BTN'(1) << focus_q;
      end else begin
         raw_hov = mouse_hover;
      end
`endif
      hov   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_BTN; k++) begin
         if (raw_hov[k] && !found) begin
            hov[k] = 1'b1;
            found  = 1'b1;
         end else begin
            hov[k] = 1'b0;
         end
      end
   end

   always_comb begin
      left_d    = mouse_left;
      left_rise = mouse_left & ~left_q;
      left_fall = ~mouse_left & left_q;
      for (int k = 0; k < NUM_BTN; k++) begin
         state_d[k]     = state_q[k];
         cnt_d[k]       = cnt_q[k];
         btn_click_d[k] = 1'b0;
         if (btn_lock[k]) begin
            state_d[k] = S_IDLE;
            cnt_d[k]   = '0;
         end else begin
            case (state_q[k])
               S_IDLE: begin
                  if (hov[k] && !mouse_left) begin
                     state_d[k] = S_HOVER;
                  end else begin
                     state_d[k] = S_IDLE;
                  end
               end
               S_HOVER: begin
                  if (!hov[k]) begin
                     state_d[k] = S_IDLE;
                  end else if (left_rise) begin
                     state_d[k] = S_PRESS;
                  end else begin
                     state_d[k] = S_HOVER;
                  end
               end
               S_PRESS: begin
                  if (!hov[k]) begin
                     state_d[k] = S_IDLE;
                  end else if (left_fall) begin
                     state_d[k]     = S_FLASH;
                     cnt_d[k]       = FLASH_LOAD;
                     btn_click_d[k] = 1'b1;
                  end else begin
                     state_d[k] = S_PRESS;
                  end
               end
               S_FLASH: begin
                  if (cnt_q[k] == '0) begin
                     state_d[k] = hov[k] ? S_HOVER : S_IDLE;
                  end else if (frame_tick) begin
                     cnt_d[k] = cnt_q[k] - CNT_W'(1);
                  end else begin
                     cnt_d[k] = cnt_q[k];
                  end
               end
               default: begin
                  state_d[k] = S_IDLE;
                  cnt_d[k]   = '0;
               end
            endcase
`ifdef MENU_BTN_KEYNAV_EN
            // A mouse button edge this cycle wins over the keyboard
            if (key_select && !left_rise && !left_fall && (focus_q == FOCUS_W'(k)) &&
                ((state_q[k] == S_IDLE) || (state_q[k] == S_HOVER))) begin
               state_d[k]     = S_FLASH;
               cnt_d[k]       = FLASH_LOAD;
               btn_click_d[k] = 1'b1;
            end else begin
               btn_click_d[k] = btn_click_d[k];
            end
`endif
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_BTN; k++) begin
         if (btn_lock[k]) begin
            btn_col[k] = C_LOCK;
         end else begin
            case (state_q[k])
               S_IDLE:  btn_col[k] = C_BLACK;
               S_HOVER: btn_col[k] = C_TOUCH;
               S_PRESS: btn_col[k] = C_CLICK;
               S_FLASH: btn_col[k] = cnt_q[k][0] ? C_CLICK : C_WHITE;
               default: btn_col[k] = C_BLACK;
            endcase
         end
      end
   end

   always_comb begin
      pixel_out_valid_d = pixel_valid;
      pixel_out_d       = C_BLACK;
      if (!pixel_valid) begin
         pixel_out_d = C_BLACK;
      end else if (mem_idx == IDX_W'(1)) begin
         pixel_out_d = C_WHITE;
      end else begin
         for (int k = 0; k < NUM_BTN; k++) begin
            if (mem_idx == IDX_W'(k + 2)) begin
               pixel_out_d = btn_col[k];
            end else begin
               pixel_out_d = pixel_out_d;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_BTN; k++) begin
            state_q[k] <= S_IDLE;
            cnt_q[k]   <= '0;
         end
         left_q          <= 1'b0;
         btn_click       <= '0;
         pixel_out       <= C_BLACK;
         pixel_out_valid <= 1'b0;
`ifdef MENU_BTN_KEYNAV_EN
         focus_q         <= '0;
`endif
      end else begin
         for (int k = 0; k < NUM_BTN; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         left_q          <= left_d;
         btn_click       <= btn_click_d;
         pixel_out       <= pixel_out_d;
         pixel_out_valid <= pixel_out_valid_d;
`ifdef MENU_BTN_KEYNAV_EN
         focus_q         <= focus_d;
`endif
      end
   end

endmodule
